// File: rtl/bitwise_logic_pipe.sv
// Two-stage bitwise logic unit with valid/ready flow control.
// Optional accumulator chaining replaces operand A with the last result.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [2:0]       inOp,
  input  logic             inAcc,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outY,
  output logic             outZero
);

  localparam logic [2:0] opAnd  = 3'b000;
  localparam logic [2:0] opOr   = 3'b001;
  localparam logic [2:0] opNot  = 3'b010;
  localparam logic [2:0] opNand = 3'b011;
  localparam logic [2:0] opNor  = 3'b100;
  localparam logic [2:0] opXor  = 3'b101;
  localparam logic [2:0] opXnor = 3'b110;
  localparam logic [2:0] opPass = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic             acc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stageOne_t;

  stageOne_t        s1;
  logic             s1Valid;
  logic             s2Valid;
  logic [WIDTH-1:0] accReg;
  logic [WIDTH-1:0] effA;
  logic [WIDTH-1:0] res;
  logic             s1Adv;
  logic             s2Adv;

  assign outValid = s2Valid;
  assign s2Adv    = s1Valid && (!s2Valid || outReady);
  assign inReady  = !reset && (!s1Valid || s2Adv);
  assign s1Adv    = inValid && inReady;

  // accReg already holds the previous S2 result, so chains run bubble-free
  assign effA = s1.acc ? accReg : s1.a;

  always_comb begin
    res = '0;
    unique case (s1.op)
      opAnd:  res = effA & s1.b;
      opOr:   res = effA | s1.b;
      opNot:  res = ~effA;
      opNand: res = ~(effA & s1.b);
      opNor:  res = ~(effA | s1.b);
      opXor:  res = effA ^ s1.b;
      opXnor: res = ~(effA ^ s1.b);
      opPass: res = s1.b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= '0;
      s1Valid <= 1'b0;
    end else if (s1Adv) begin
      s1.op   <= inOp;
      s1.acc  <= inAcc;
      s1.a    <= inA;
      s1.b    <= inB;
      s1Valid <= 1'b1;
    end else if (s2Adv) begin
      s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2Valid <= 1'b0;
      outY    <= '0;
      outZero <= 1'b0;
      accReg  <= '0;
    end else if (s2Adv) begin
      s2Valid <= 1'b1;
      outY    <= res;
      outZero <= (res == '0);
      accReg  <= res;
    end else if (outReady) begin
      s2Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed bench for bitwise_logic_pipe (WIDTH=8 and WIDTH=16 instances).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bitwise_logic_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inOp;
  logic        inAcc;
  logic [7:0]  inA;
  logic [7:0]  inB;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outY;
  logic        outZero;

  logic        wInValid;
  logic        wInReady;
  logic [2:0]  wInOp;
  logic        wInAcc;
  logic [15:0] wInA;
  logic [15:0] wInB;
  logic        wOutValid;
  logic        wOutReady;
  logic [15:0] wOutY;
  logic        wOutZero;

  int nRun  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  bitwise_logic_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .inOp(inOp), .inAcc(inAcc), .inA(inA), .inB(inB),
    .outValid(outValid), .outReady(outReady),
    .outY(outY), .outZero(outZero)
  );

  bitwise_logic_pipe #(.WIDTH(16)) dutW (
    .clk(clk), .reset(reset),
    .inValid(wInValid), .inReady(wInReady),
    .inOp(wInOp), .inAcc(wInAcc), .inA(wInA), .inB(wInB),
    .outValid(wOutValid), .outReady(wOutReady),
    .outY(wOutY), .outZero(wOutZero)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    nRun++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op,
                       input logic acc, input logic [7:0] a,
                       input logic [7:0] b);
    inValid = v;
    inOp    = op;
    inAcc   = acc;
    inA     = a;
    inB     = b;
  endtask

  logic [7:0] allExp [8];
  logic [7:0] chainExp [5];
  logic [2:0] chainOp [5];
  logic [7:0] chainB [5];

  initial begin
    allExp = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h0F};
    chainOp = '{3'b111, 3'b101, 3'b000, 3'b010, 3'b101};
    chainB  = '{8'hFF, 8'h0F, 8'h3C, 8'h00, 8'hCF};
    chainExp = '{8'hFF, 8'hF0, 8'h30, 8'hCF, 8'h00};

    reset     = 1'b1;
    outReady  = 1'b1;
    drive(1'b1, 3'b111, 1'b0, 8'h00, 8'h77);
    wInValid  = 1'b0;
    wInOp     = 3'b000;
    wInAcc    = 1'b0;
    wInA      = '0;
    wInB      = '0;
    wOutReady = 1'b1;

    // reset state; a transaction offered during reset is ignored
    tick();
    tick();
    check("rst_inReady", {15'd0, inReady}, 16'd0);
    check("rst_outValid", {15'd0, outValid}, 16'd0);
    check("rst_outY", {8'd0, outY}, 16'h0000);
    check("rst_outZero", {15'd0, outZero}, 16'd0);
    reset = 1'b0;
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    #1;
    check("post_rst_inReady", {15'd0, inReady}, 16'd1);
    tick();
    tick();
    check("rst_offer_dropped", {15'd0, outValid}, 16'd0);

    // basic AND
    drive(1'b1, 3'b000, 1'b0, 8'hF0, 8'h3C);
    tick();
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    check("and_not_yet", {15'd0, outValid}, 16'd0);
    tick();
    check("and_valid", {15'd0, outValid}, 16'd1);
    check("and_y", {8'd0, outY}, 16'h0030);
    check("and_zero", {15'd0, outZero}, 16'd0);
    tick();
    check("and_one_cycle", {15'd0, outValid}, 16'd0);

    // all ops back-to-back
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 3'(i), 1'b0, 8'hA5, 8'h0F);
      else       drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
      tick();
      if (i >= 1) begin
        check($sformatf("ops_valid%0d", i - 1), {15'd0, outValid}, 16'd1);
        check($sformatf("ops_y%0d", i - 1), {8'd0, outY},
              {8'd0, allExp[i-1]});
      end
    end
    tick();
    check("ops_drained", {15'd0, outValid}, 16'd0);

    // backpressure
    outReady = 1'b0;
    drive(1'b1, 3'b001, 1'b0, 8'h00, 8'h01);
    tick();
    check("bp_ready1", {15'd0, inReady}, 16'd1);
    drive(1'b1, 3'b001, 1'b0, 8'h00, 8'h02);
    tick();
    check("bp_full_ready", {15'd0, inReady}, 16'd0);
    check("bp_valid", {15'd0, outValid}, 16'd1);
    check("bp_y_a", {8'd0, outY}, 16'h0001);
    drive(1'b1, 3'b001, 1'b0, 8'h00, 8'h04);
    tick();
    check("bp_hold_ready", {15'd0, inReady}, 16'd0);
    check("bp_y_hold", {8'd0, outY}, 16'h0001);
    outReady = 1'b1;
    #1;
    check("bp_release_ready", {15'd0, inReady}, 16'd1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    check("bp_y_b", {8'd0, outY}, 16'h0002);
    tick();
    check("bp_y_c", {8'd0, outY}, 16'h0004);
    check("bp_valid_c", {15'd0, outValid}, 16'd1);
    tick();
    check("bp_drained", {15'd0, outValid}, 16'd0);

    // accumulator chain without bubbles
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, chainOp[i], (i != 0), 8'h5A, chainB[i]);
      else       drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
      tick();
      if (i >= 1) begin
        check($sformatf("acc_valid%0d", i - 1), {15'd0, outValid}, 16'd1);
        check($sformatf("acc_y%0d", i - 1), {8'd0, outY},
              {8'd0, chainExp[i-1]});
        check($sformatf("acc_zero%0d", i - 1), {15'd0, outZero},
              {15'd0, (i == 5)});
      end
    end
    tick();

    // reset mid-operation
    drive(1'b1, 3'b111, 1'b0, 8'h00, 8'h11);
    tick();
    drive(1'b1, 3'b111, 1'b0, 8'h00, 8'h22);
    tick();
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    #1;
    check("mid_rst_inReady", {15'd0, inReady}, 16'd0);
    tick();
    reset = 1'b0;
    check("mid_rst_valid", {15'd0, outValid}, 16'd0);
    tick();
    check("mid_rst_stale1", {15'd0, outValid}, 16'd0);
    tick();
    check("mid_rst_stale2", {15'd0, outValid}, 16'd0);
    drive(1'b1, 3'b001, 1'b1, 8'hFF, 8'h01);
    tick();
    drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00);
    tick();
    check("mid_rst_acc_valid", {15'd0, outValid}, 16'd1);
    check("mid_rst_acc_y", {8'd0, outY}, 16'h0001);

    // wider instance
    wInValid = 1'b1;
    wInOp    = 3'b011;
    wInA     = 16'hFFFF;
    wInB     = 16'hFFFF;
    tick();
    wInValid = 1'b0;
    tick();
    check("w16_valid", {15'd0, wOutValid}, 16'd1);
    check("w16_y", wOutY, 16'h0000);
    check("w16_zero", {15'd0, wOutZero}, 16'd1);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
